// File: rtl/multicycle_adder_subtractor_pkg.sv
// Shared types for the multi-cycle adder/subtractor.
// FSM encoding and index-width helper.
package multicycle_adder_subtractor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// CHUNK-bit ripple of one-bit full-adder cells.
// cmsb is the carry entering the top bit, used for signed overflow.
module adder_chunk #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [CHUNK:0] w_c;

  always_comb begin
    w_c    = '0;
    sum    = '0;
    w_c[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      sum[i]   = a[i] ^ b[i] ^ w_c[i];
      w_c[i+1] = (a[i] & b[i])
               | (w_c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = w_c[CHUNK];
  assign cmsb = w_c[CHUNK-1];

endmodule

// File: rtl/multicycle_adder_subtractor.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock,
// carry rippled between chunks through r_carry.
module multicycle_adder_subtractor
  import multicycle_adder_subtractor_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             subtract,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow,
  output logic             zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = idx_bits(NCHUNK);
  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

  state_t r_state;
  state_t w_state_nx;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic [IW-1:0]    r_idx;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;

  logic             w_accept;
  logic             w_run;
  logic             w_last;
  logic [CHUNK-1:0] w_ch_sum;
  logic             w_ch_cout;
  logic             w_ch_cmsb;
  logic [WIDTH-1:0] w_sum_nx;

  assign w_accept = in_valid && (r_state == ST_IDLE);
  assign w_run    = (r_state == ST_RUN);
  assign w_last   = (r_idx == LAST);

  // Operands shift right so the active chunk is always the low bits.
  adder_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .a    (r_a[CHUNK-1:0]),
    .b    (r_b[CHUNK-1:0]),
    .cin  (r_carry),
    .sum  (w_ch_sum),
    .cout (w_ch_cout),
    .cmsb (w_ch_cmsb)
  );

  // Result shifts in from the top; after NCHUNK steps it is aligned.
  assign w_sum_nx = WIDTH'({w_ch_sum, r_sum} >> CHUNK);

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      ST_IDLE: if (in_valid)  w_state_nx = ST_RUN;
      ST_RUN:  if (w_last)    w_state_nx = ST_DONE;
      ST_DONE: if (out_ready) w_state_nx = ST_IDLE;
      default:                w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b ^ {WIDTH{subtract}};
      r_carry <= subtract;
      r_idx   <= '0;
    end else if (w_run) begin
      r_a     <= r_a >> CHUNK;
      r_b     <= r_b >> CHUNK;
      r_sum   <= w_sum_nx;
      r_carry <= w_ch_cout;
      r_idx   <= r_idx + IW'(1);
      if (w_last) begin
        r_cout <= w_ch_cout;
        r_ovf  <= w_ch_cmsb ^ w_ch_cout;
        r_zero <= ~|w_sum_nx;
      end
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign sum       = r_sum;
  assign carryout  = r_cout;
  assign overflow  = r_ovf;
  assign zero      = r_zero;

endmodule
